// File: rtl/ps2_direction_decoder.sv
// PS/2 Set-2 receiver that turns arrow keys into a held one-hot direction with valid/ack,
// and the S key into a one-cycle start pulse. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       dir_ack,
    output logic [3:0] direction,
    output logic       dir_valid,
    output logic       start_pulse,
    output logic       rx_error
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_S     = 8'h1B;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_e;

    // ---------------------------------------------------------------- input sync
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_fall;
    logic                   ps2_dat;

    // NOTE: synchroniser stages reset to 1 (idle bus level) so reset release never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ps2_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat  = dat_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------- receiver
    rx_state_e   rx_state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic        byte_valid_q;
    logic        rx_err_q;
    logic [TW-1:0] tmo_q;
    logic        frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    assign frame_ok = ps2_dat & (^{shift_q, parity_q});
`else
    assign frame_ok = ps2_dat;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
            tmo_q        <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;

            if (ps2_fall || rx_state_q == RX_IDLE) tmo_q <= '0;
            else                                   tmo_q <= tmo_q + 1'b1;

            if (ps2_fall) begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!ps2_dat) begin
                            rx_state_q <= RX_DATA;
                            bit_cnt_q  <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {ps2_dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_q   <= ps2_dat;
`endif
                        rx_state_q <= RX_STOP;
                    end
                    default: begin
                        if (frame_ok) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            rx_err_q     <= 1'b1;
                        end
                        rx_state_q <= RX_IDLE;
                    end
                endcase
            end else if (rx_state_q != RX_IDLE && tmo_q == TMO_LAST) begin
                rx_err_q   <= 1'b1;
                rx_state_q <= RX_IDLE;
            end
        end
    end

    // ---------------------------------------------------------------- decoder
    function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
        case (code)
            8'h75:   return 4'b1000;
            8'h72:   return 4'b0100;
            8'h6B:   return 4'b0010;
            8'h74:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    dec_state_e  dec_state_q;
    logic [4:0]  held_q;          // {S, up, down, left, right}
    logic [3:0]  dir_q;
    logic        dir_valid_q;
    logic        start_q;
    logic [3:0]  arrow_d;
    logic        arrow_accept_d;
    logic        s_accept_d;

    always_comb begin
        arrow_d        = arrow_onehot(byte_q);
        arrow_accept_d = byte_valid_q && dec_state_q == D_EXT &&
                         arrow_d != 4'b0000 && (held_q[3:0] & arrow_d) == 4'b0000;
        s_accept_d     = byte_valid_q && dec_state_q == D_IDLE &&
                         byte_q == CODE_S && !held_q[4];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_state_q <= D_IDLE;
            held_q      <= '0;
            dir_q       <= '0;
            dir_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            start_q <= s_accept_d;

            if (rx_err_q) begin
                dec_state_q <= D_IDLE;
            end else if (byte_valid_q) begin
                case (dec_state_q)
                    D_IDLE: begin
                        if (byte_q == CODE_EXT)        dec_state_q <= D_EXT;
                        else if (byte_q == CODE_BREAK) dec_state_q <= D_BRK;
                        else if (byte_q == CODE_S)     held_q[4]   <= 1'b1;
                    end
                    D_EXT: begin
                        if (byte_q == CODE_BREAK) begin
                            dec_state_q <= D_EXTBRK;
                        end else begin
                            held_q[3:0] <= held_q[3:0] | arrow_d;
                            dec_state_q <= D_IDLE;
                        end
                    end
                    D_BRK: begin
                        if (byte_q == CODE_S) held_q[4] <= 1'b0;
                        dec_state_q <= D_IDLE;
                    end
                    default: begin
                        held_q[3:0] <= held_q[3:0] & ~arrow_d;
                        dec_state_q <= D_IDLE;
                    end
                endcase
            end

            // First press wins unless the consumer acks in the same cycle.
            if (arrow_accept_d && (!dir_valid_q || dir_ack)) begin
                dir_q       <= arrow_d;
                dir_valid_q <= 1'b1;
            end else if (dir_ack && dir_valid_q) begin
                dir_q       <= '0;
                dir_valid_q <= 1'b0;
            end
        end
    end

    assign direction   = dir_q;
    assign dir_valid   = dir_valid_q;
    assign start_pulse = start_q;
    assign rx_error    = rx_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: expected output events are queued as PS/2 frames
// are driven and matched against dir_valid loads, start pulses and rx_error pulses as they appear.
module tb_ps2_direction_decoder;

    localparam int TMO  = 200;
    localparam int HALF = 20;
    localparam int GAP  = 12;

    typedef enum logic [1:0] {EV_DIR, EV_START, EV_ERR} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [3:0] dir;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       dir_ack;
    logic [3:0] direction;
    logic       dir_valid;
    logic       start_pulse;
    logic       rx_error;

    ev_t        sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_dir   = 4'b0000;

    ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .dir_ack     (dir_ack),
        .direction   (direction),
        .dir_valid   (dir_valid),
        .start_pulse (start_pulse),
        .rx_error    (rx_error)
    );

    always #5 clock = ~clock;

    task automatic push(input ev_kind_e k, input logic [3:0] d);
        ev_t e;
        e.kind = k;
        e.dir  = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [3:0] d);
        ev_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d dir=%b, required no event", k, d);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== k || e.dir !== d) begin
                n_fail++;
                $display("FAIL event_order: got kind=%0d dir=%b, required kind=%0d dir=%b",
                         k, d, e.kind, e.dir);
            end
        end
    endtask

    // Every cycle: compare whatever the DUT produced against the queue head.
    task automatic tick();
        @(negedge clock);
        if (!reset) begin
            if (rx_error === 1'b1)    expect_ev(EV_ERR, 4'b0000);
            if (start_pulse === 1'b1) expect_ev(EV_START, 4'b0000);
            if (dir_valid === 1'b1 && (!prev_valid || direction !== prev_dir))
                expect_ev(EV_DIR, direction);
        end
        prev_valid = (dir_valid === 1'b1);
        prev_dir   = direction;
    endtask

    task automatic drained(input string name);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_events: got %0d outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) tick();
        ps2_clk = 1'b0;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_good ? ~^b : ^b);
        ps2_bit(stop);
        ps2_dat = 1'b1;
        repeat (GAP) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1);
    endtask

    task automatic ack_and_check(input string name);
        dir_ack = 1'b1;
        tick();
        dir_ack = 1'b0;
        n_checks++;
        if (dir_valid !== 1'b0 || direction !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_ack: got valid=%b dir=%b, required valid=0 dir=0000",
                     name, dir_valid, direction);
        end
    endtask

    task automatic check_dir(input string name, input logic v, input logic [3:0] d);
        n_checks++;
        if (dir_valid !== v || direction !== d) begin
            n_fail++;
            $display("FAIL %s: got valid=%b dir=%b, required valid=%b dir=%b",
                     name, dir_valid, direction, v, d);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        dir_ack = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({direction, dir_valid, start_pulse, rx_error} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required 0000000",
                     {direction, dir_valid, start_pulse, rx_error});
        end
    endtask

    task automatic test_hold_ack();
        int bad = 0;
        push(EV_DIR, 4'b1000);
        send_byte(8'hE0);
        send_byte(8'h75);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (dir_valid !== 1'b1 || direction !== 4'b1000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_without_ack: got %0d bad cycles, required 0", bad);
        end
        ack_and_check("hold");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        drained("hold");
    endtask

    task automatic test_typematic();
        push(EV_DIR, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0);
            send_byte(8'h74);
            ack_and_check("typematic_rep");
        end
        drained("typematic_repeat");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        push(EV_DIR, 4'b0001);
        send_byte(8'hE0); send_byte(8'h74);
        check_dir("typematic_after_break", 1'b1, 4'b0001);
        ack_and_check("typematic");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        drained("typematic");
    endtask

    task automatic test_first_wins();
        push(EV_DIR, 4'b0010);
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h72);
        check_dir("first_press_wins", 1'b1, 4'b0010);
        ack_and_check("first_wins");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        drained("first_wins");
    endtask

    task automatic test_start();
        push(EV_START, 4'b0000);
        send_byte(8'h1B);
        send_byte(8'h1B);
        check_dir("start_no_dir", 1'b0, 4'b0000);
        send_byte(8'hF0); send_byte(8'h1B);
        push(EV_START, 4'b0000);
        send_byte(8'h1B);
        send_byte(8'hF0); send_byte(8'h1B);
        drained("start");
    endtask

    task automatic test_errors();
        push(EV_ERR, 4'b0000);
        send_frame(8'hE0, 1'b1, 1'b0);
        push(EV_ERR, 4'b0000);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (TMO + 60) tick();
        check_dir("errors_no_output", 1'b0, 4'b0000);
        drained("errors");
        push(EV_DIR, 4'b1000);
        send_byte(8'hE0); send_byte(8'h75);
        check_dir("after_errors", 1'b1, 4'b1000);
        ack_and_check("errors");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        drained("after_errors");
    endtask

    task automatic test_parity();
        send_byte(8'hE0);
`ifdef PS2_PARITY_CHECK_EN
        push(EV_ERR, 4'b0000);
        send_frame(8'h75, 1'b0, 1'b1);
        check_dir("bad_parity_rejected", 1'b0, 4'b0000);
`else
        push(EV_DIR, 4'b1000);
        send_frame(8'h75, 1'b0, 1'b1);
        check_dir("parity_ignored", 1'b1, 4'b1000);
        ack_and_check("parity");
`endif
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        drained("parity");
    endtask

    task automatic test_reset_mid_frame();
        push(EV_DIR, 4'b1000);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({direction, dir_valid, start_pulse, rx_error} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %b, required 0000000",
                     {direction, dir_valid, start_pulse, rx_error});
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        reset   = 1'b0;
        repeat (GAP) tick();
        push(EV_DIR, 4'b1000);
        send_byte(8'hE0); send_byte(8'h75);
        check_dir("after_reset_frame", 1'b1, 4'b1000);
        drained("reset_mid_frame");
    endtask

    initial begin
        test_reset();
        test_hold_ack();
        test_typematic();
        test_first_wins();
        test_start();
        test_errors();
        test_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
